// File: rtl/home_actuator_driver.sv
// Actuator drive stage behind the home automation controller: door-lock pulses,
// buzzer patterns, compressor min on/off protection, 7-seg decode. Optional macro: BUZZ_MUTE_EN.
//   state    | meaning
//   BZ_IDLE  | buzzer silent
//   BZ_ALARM | fire-alarm pattern, ALARM_HALF ticks per half-period
//   BZ_WIN   | window-warning pattern, WIN_HALF ticks per half-period
//   CL_OFF   | no climate drive, hold counts off-time
//   CL_COOL  | cooler compressor enabled
//   CL_HEAT  | heater enabled
module home_actuator_driver #(
  parameter int TICK_DIV   = 1000,
  parameter int DOOR_PULSE = 4,
  parameter int MIN_HOLD   = 8,
  parameter int ALARM_HALF = 1,
  parameter int WIN_HALF   = 4
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       fdoor,
  input  logic       rdoor,
  input  logic       winbuzz,
  input  logic       alarmbuzz,
  input  logic       cooler,
  input  logic       heater,
`ifdef BUZZ_MUTE_EN
  input  logic       mute,
`endif
  input  logic [2:0] display,
  output logic       fdoor_drv,
  output logic       rdoor_drv,
  output logic       buzz_out,
  output logic       cooler_en,
  output logic       heater_en,
  output logic [6:0] seg
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DOOR_PULSE + 1);
  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam int BH = (ALARM_HALF > WIN_HALF) ? ALARM_HALF : WIN_HALF;
  localparam int BW = $clog2(BH + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DOOR_LAST  = DW'(DOOR_PULSE - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(MIN_HOLD);
  localparam logic [BW-1:0] ALARM_LAST = BW'(ALARM_HALF - 1);
  localparam logic [BW-1:0] WIN_LAST   = BW'(WIN_HALF - 1);

  typedef enum logic [1:0] {BZ_IDLE, BZ_ALARM, BZ_WIN} bz_state_t;
  typedef enum logic [1:0] {CL_OFF, CL_COOL, CL_HEAT} cl_state_t;

  logic [TW-1:0] tick_cnt;
  logic          tick;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst)      tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == TICK_LAST);

  // index 0 = front door, 1 = rear door; each has its own pulse tick count
  logic [1:0]          door_in, door_q, door_drv;
  logic [1:0][DW-1:0]  door_cnt;

  assign door_in = {rdoor, fdoor};

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      door_q   <= '0;
      door_drv <= '0;
      door_cnt <= '0;
    end else begin
      door_q <= door_in;
      for (int i = 0; i < 2; i++) begin
        if (door_in[i] && !door_q[i]) begin
          door_drv[i] <= 1'b1;
          door_cnt[i] <= '0;
        end else if (door_drv[i] && tick) begin
          if (door_cnt[i] == DOOR_LAST) begin
            door_drv[i] <= 1'b0;
            door_cnt[i] <= '0;
          end else begin
            door_cnt[i] <= door_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign fdoor_drv = door_drv[0];
  assign rdoor_drv = door_drv[1];

  bz_state_t     bz_state, bz_next;
  logic [BW-1:0] half_cnt, half_last;
  logic          buzz_q;

  always_comb begin
    bz_next   = BZ_IDLE;
    half_last = WIN_LAST;
    if (alarmbuzz)    bz_next = BZ_ALARM;
    else if (winbuzz) bz_next = BZ_WIN;
    if (bz_state == BZ_ALARM) half_last = ALARM_LAST;
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      bz_state <= BZ_IDLE;
      buzz_q   <= 1'b0;
      half_cnt <= '0;
    end else begin
      bz_state <= bz_next;
      if (bz_next == BZ_IDLE) begin
        buzz_q   <= 1'b0;
        half_cnt <= '0;
      end else if (bz_next != bz_state) begin
        buzz_q   <= 1'b1;
        half_cnt <= '0;
      end else if (tick) begin
        if (half_cnt == half_last) begin
          buzz_q   <= ~buzz_q;
          half_cnt <= '0;
        end else begin
          half_cnt <= half_cnt + 1'b1;
        end
      end
    end
  end

`ifdef BUZZ_MUTE_EN
  // mute only silences the window warning; the pattern keeps running underneath
  assign buzz_out = buzz_q && !(mute && bz_state == BZ_WIN);
`else
  assign buzz_out = buzz_q;
`endif

  cl_state_t     cl_state, cl_next;
  logic [HW-1:0] hold_cnt;
  logic          cool_only, heat_only, hold_full;

  assign cool_only = cooler && !heater;
  assign heat_only = heater && !cooler;
  assign hold_full = (hold_cnt == HOLD_MAX);

  always_comb begin
    cl_next = cl_state;
    case (cl_state)
      CL_OFF: begin
        if (cool_only && hold_full)      cl_next = CL_COOL;
        else if (heat_only && hold_full) cl_next = CL_HEAT;
      end
      CL_COOL: if (!cool_only && hold_full) cl_next = CL_OFF;
      CL_HEAT: if (!heat_only && hold_full) cl_next = CL_OFF;
      default: cl_next = CL_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      cl_state  <= CL_OFF;
      hold_cnt  <= HOLD_MAX;
      cooler_en <= 1'b0;
      heater_en <= 1'b0;
    end else begin
      cl_state  <= cl_next;
      cooler_en <= (cl_next == CL_COOL);
      heater_en <= (cl_next == CL_HEAT);
      if (cl_next != cl_state)      hold_cnt <= '0;
      else if (tick && !hold_full)  hold_cnt <= hold_cnt + 1'b1;
    end
  end

  logic [6:0] seg_d;

  always_comb begin
    seg_d = 7'h00;
    case (display)
      3'd0: seg_d = 7'h3F;
      3'd1: seg_d = 7'h06;
      3'd2: seg_d = 7'h5B;
      3'd3: seg_d = 7'h4F;
      3'd4: seg_d = 7'h66;
      3'd5: seg_d = 7'h6D;
      3'd6: seg_d = 7'h7D;
      3'd7: seg_d = 7'h07;
      default: seg_d = 7'h00;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) seg <= 7'h00;
    else      seg <= seg_d;
  end

endmodule
